// File: rtl/vp_pixel_pipe.sv
// vp_pixel_pipe: RGB-to-gray point-operation pipeline with raster tagging and a FWFT output FIFO.
// Define VP_PIXEL_PIPE_STATS_EN to build the frame and stall counters.
module vp_pixel_pipe #(
  parameter int CW = 4,
  parameter int DW = 8,
  parameter int RL = 640,
  parameter int FL = 480,
  parameter int AW = 10
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic [1:0]      i_mode,
  input  logic [DW-1:0]   i_threshold,
  input  logic            i_data_valid,
  output logic            o_data_ready,
  input  logic [3*CW-1:0] i_data,
  input  logic            i_data_ready,
  output logic            o_data_valid,
  output logic [DW-1:0]   o_data,
  output logic            o_sof,
  output logic            o_eol,
  output logic [AW:0]     o_fill,
  output logic [15:0]     o_frame_count,
  output logic [31:0]     o_stall_cycles
);

  localparam int COLW  = (RL > 1) ? $clog2(RL) : 1;
  localparam int ROWW  = (FL > 1) ? $clog2(FL) : 1;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0]   FILL_LIMIT = (AW+1)'(DEPTH - 4);
  localparam logic [COLW-1:0] COL_LAST = COLW'(RL - 1);
  localparam logic [ROWW-1:0] ROW_LAST = ROWW'(FL - 1);

  // Widen a channel to DW bits by repeating its bit pattern from the MSB down.
  function automatic logic [DW-1:0] widen(input logic [CW-1:0] c);
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < DW; i++) w[DW-1-i] = c[CW-1-(i % CW)];
    return w;
  endfunction

  function automatic logic [DW-1:0] gray_f(input logic [DW-1:0] r, input logic [DW-1:0] g,
                                           input logic [DW-1:0] b);
    logic [DW+7:0] acc;
    acc = (DW+8)'(77)  * {8'd0, r}
        + (DW+8)'(150) * {8'd0, g}
        + (DW+8)'(29)  * {8'd0, b};
    return acc[DW+7:8];
  endfunction

  function automatic logic [DW-1:0] point_op(input logic [1:0] mode, input logic [DW-1:0] g,
                                             input logic [DW-1:0] thr);
    logic [DW-1:0] r;
    r = g;
    case (mode)
      2'd1:    r = (g >= thr) ? '1 : '0;
      2'd2:    r = ~g;
      2'd3:    r = (g >= thr) ? g : '0;
      default: r = g;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [AW:0]     fill_q, fill_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [COLW-1:0] col_q, col_d;
  logic [ROWW-1:0] row_q, row_d;
  logic [1:0]      mode_q;
  logic [DW-1:0]   thr_q;
  logic            accept, col_last, row_last, sof_in;
  logic [1:0]      mode_sel;
  logic [DW-1:0]   thr_sel;

  assign o_data_ready = i_rstn && (fill_q <= FILL_LIMIT);
  assign accept       = i_data_valid && o_data_ready;
  assign col_last     = (col_q == COL_LAST);
  assign row_last     = (row_q == ROW_LAST);
  assign sof_in       = (col_q == '0) && (row_q == '0);
  // The sof pixel already uses the operation being latched for its frame.
  assign mode_sel     = sof_in ? i_mode : mode_q;
  assign thr_sel      = sof_in ? i_threshold : thr_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + ROWW'(1);
      end else begin
        col_d = col_q + COLW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      col_q  <= '0;
      row_q  <= '0;
      mode_q <= '0;
      thr_q  <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      if (accept && sof_in) begin
        mode_q <= i_mode;
        thr_q  <= i_threshold;
      end
    end
  end

  // ---- stage 1: accepted pixel, widened channels, tags, effective operation
  logic            vld_p1_q, sof_p1_q, eol_p1_q;
  logic [1:0]      mode_p1_q;
  logic [DW-1:0]   thr_p1_q, r_p1_q, g_p1_q, b_p1_q;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) vld_p1_q <= 1'b0;
    else         vld_p1_q <= accept;
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      r_p1_q    <= widen(i_data[3*CW-1:2*CW]);
      g_p1_q    <= widen(i_data[2*CW-1:CW]);
      b_p1_q    <= widen(i_data[CW-1:0]);
      sof_p1_q  <= sof_in;
      eol_p1_q  <= col_last;
      mode_p1_q <= mode_sel;
      thr_p1_q  <= thr_sel;
    end
  end

  // ---- stage 2: grayscale
  logic            vld_p2_q, sof_p2_q, eol_p2_q;
  logic [1:0]      mode_p2_q;
  logic [DW-1:0]   thr_p2_q, gray_p2_q;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) vld_p2_q <= 1'b0;
    else         vld_p2_q <= vld_p1_q;
  end

  always_ff @(posedge i_clk) begin
    if (vld_p1_q) begin
      gray_p2_q <= gray_f(r_p1_q, g_p1_q, b_p1_q);
      sof_p2_q  <= sof_p1_q;
      eol_p2_q  <= eol_p1_q;
      mode_p2_q <= mode_p1_q;
      thr_p2_q  <= thr_p1_q;
    end
  end

  // ---- stage 3: point operation and FIFO write
  logic [DW+1:0] mem_q [DEPTH];
  logic [DW+1:0] head;
  logic          push, pop, fifo_vld;

  assign push     = vld_p2_q;
  assign fifo_vld = (fill_q != '0);
  assign pop      = fifo_vld && i_data_ready;
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    fill_d = fill_q;
    case ({push, pop})
      2'b10:   fill_d = fill_q + (AW+1)'(1);
      2'b01:   fill_d = fill_q - (AW+1)'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= {sof_p2_q, eol_p2_q, point_op(mode_p2_q, gray_p2_q, thr_p2_q)};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      fill_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      fill_q <= fill_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  assign o_data_valid = fifo_vld;
  assign o_data       = fifo_vld ? head[DW-1:0] : '0;
  assign o_eol        = fifo_vld && head[DW];
  assign o_sof        = fifo_vld && head[DW+1];
  assign o_fill       = fill_q;

`ifdef VP_PIXEL_PIPE_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    stall_d     = stall_q;
    if (accept && row_last && col_last) frame_cnt_d = frame_cnt_q + 16'd1;
    if (i_data_valid && !o_data_ready)  stall_d     = sat_inc32(stall_q);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      frame_cnt_q <= '0;
      stall_q     <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      stall_q     <= stall_d;
    end
  end

  assign o_frame_count  = frame_cnt_q;
  assign o_stall_cycles = stall_q;
`else
  assign o_frame_count  = '0;
  assign o_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_vp_pixel_pipe.sv
// Directed bench for vp_pixel_pipe with a small raster (4x2) and a 16-entry FIFO.
module tb_vp_pixel_pipe;
  localparam int CW = 4, DW = 8, RL = 4, FL = 2, AW = 4;

  logic              i_clk = 1'b0;
  logic              i_rstn = 1'b0;
  logic [1:0]        i_mode = '0;
  logic [DW-1:0]     i_threshold = '0;
  logic              i_data_valid = 1'b0;
  logic              o_data_ready;
  logic [3*CW-1:0]   i_data = '0;
  logic              i_data_ready = 1'b0;
  logic              o_data_valid;
  logic [DW-1:0]     o_data;
  logic              o_sof, o_eol;
  logic [AW:0]       o_fill;
  logic [15:0]       o_frame_count;
  logic [31:0]       o_stall_cycles;

  vp_pixel_pipe #(.CW(CW), .DW(DW), .RL(RL), .FL(FL), .AW(AW)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_mode(i_mode), .i_threshold(i_threshold),
    .i_data_valid(i_data_valid), .o_data_ready(o_data_ready), .i_data(i_data),
    .i_data_ready(i_data_ready), .o_data_valid(o_data_valid), .o_data(o_data),
    .o_sof(o_sof), .o_eol(o_eol), .o_fill(o_fill), .o_frame_count(o_frame_count),
    .o_stall_cycles(o_stall_cycles)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  thr;
    logic [11:0] rgb;
    logic [7:0]  exp;
  } vec_t;
  vec_t vecs[20];

  typedef struct {
    logic       sof;
    logic       eol;
    logic [7:0] data;
    int         c;
  } out_t;
  out_t outq[$];

  // Record every pop (valid && ready before the edge); also watch for FIFO overflow.
  always @(negedge i_clk) begin
    if (i_rstn && o_data_valid && i_data_ready) outq.push_back('{o_sof, o_eol, o_data, cyc});
    n_checks++;
    if (o_fill > 5'd16) begin
      n_fail++;
      $display("FAIL fifo_overflow: o_fill=%0d limit=16", o_fill);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    i_data_valid = 1'b0;
    i_rstn = 1'b0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rstn = 1'b1;
    outq.delete();
  endtask

  task automatic push(input logic [11:0] px);
    bit done, rdy;
    done = 0;
    i_data = px;
    i_data_valid = 1'b1;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge i_clk);
      rdy = o_data_ready;
      @(posedge i_clk); #1;
      if (rdy) done = 1;
    end
    i_data_valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: pixel %h not accepted within 40 cycles", px);
    end
  endtask

  task automatic wait_out(input int n);
    for (int t = 0; t < 80 && outq.size() < n; t++) @(posedge i_clk);
    #1;
    if (outq.size() < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL out_timeout: got %0d outputs expected %0d", outq.size(), n);
    end
  endtask

  task automatic check_out(input string name, input int idx, input logic [7:0] exp_d,
                           input logic exp_sof, input logic exp_eol, input bit tags);
    if (idx >= outq.size()) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s[%0d]: output missing, expected %0d", name, idx, exp_d);
    end else begin
      check($sformatf("%s[%0d].data", name, idx), outq[idx].data, exp_d);
      if (tags) begin
        check($sformatf("%s[%0d].sof", name, idx), outq[idx].sof, exp_sof);
        check($sformatf("%s[%0d].eol", name, idx), outq[idx].eol, exp_eol);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [11:0] stream [5];
    logic [3:0]  k4;
    logic [7:0]  e;
    int          exp_fc, exp_st;

    stream = '{12'hF00, 12'h0F0, 12'h00F, 12'hFFF, 12'h000};
    for (int j = 0; j < 5; j++) begin
      vecs[j]      = '{2'd0, 8'd0,   stream[j], 8'd0};
      vecs[5 + j]  = '{2'd1, 8'd100, stream[j], 8'd0};
      vecs[10 + j] = '{2'd2, 8'd0,   stream[j], 8'd0};
      vecs[15 + j] = '{2'd3, 8'd100, stream[j], 8'd0};
    end
    vecs[0].exp  = 8'd76;  vecs[1].exp  = 8'd149; vecs[2].exp  = 8'd28;
    vecs[3].exp  = 8'd255; vecs[4].exp  = 8'd0;
    vecs[5].exp  = 8'd0;   vecs[6].exp  = 8'd255; vecs[7].exp  = 8'd0;
    vecs[8].exp  = 8'd255; vecs[9].exp  = 8'd0;
    vecs[10].exp = 8'd179; vecs[11].exp = 8'd106; vecs[12].exp = 8'd227;
    vecs[13].exp = 8'd0;   vecs[14].exp = 8'd255;
    vecs[15].exp = 8'd0;   vecs[16].exp = 8'd149; vecs[17].exp = 8'd0;
    vecs[18].exp = 8'd255; vecs[19].exp = 8'd0;

    // Reset state
    i_data_valid = 1'b1;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    check("rst_ready", o_data_ready, 0);
    check("rst_valid", o_data_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_sof", o_sof, 0);
    check("rst_eol", o_eol, 0);
    check("rst_fill", o_fill, 0);
    check("rst_frame_count", o_frame_count, 0);
    check("rst_stall", o_stall_cycles, 0);
    i_data_valid = 1'b0;
    i_rstn = 1'b1;
    #1;
    check("ready_after_rst", o_data_ready, 1);

    // Latency: output valid appears after the second edge following the accept
    apply_reset();
    i_mode = 2'd0;
    i_data_ready = 1'b1;
    push(12'hFFF);
    @(negedge i_clk); check("lat_valid_n1", o_data_valid, 0);
    @(negedge i_clk); check("lat_valid_n2", o_data_valid, 0);
    @(negedge i_clk); check("lat_valid_n3", o_data_valid, 1);
    check("lat_data", o_data, 255);
    check("lat_sof", o_sof, 1);

    // Table-driven: each mode on a fresh frame, five pixels back-to-back
    for (int g = 0; g < 4; g++) begin
      apply_reset();
      i_mode = vecs[g * 5].mode;
      i_threshold = vecs[g * 5].thr;
      i_data_ready = 1'b1;
      for (int j = 0; j < 5; j++) push(vecs[g * 5 + j].rgb);
      wait_out(5);
      for (int j = 0; j < 5; j++)
        check_out($sformatf("mode%0d", g), j, vecs[g * 5 + j].exp, 1'b0, 1'b0, 0);
      if (g == 0 && outq.size() >= 5) check("throughput_span", outq[4].c - outq[0].c, 4);
    end

    // Mode change mid-frame takes effect only at the next sof
    apply_reset();
    i_mode = 2'd0;
    i_threshold = 8'd0;
    i_data_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      k4 = 4'(i + 1);
      push({k4, k4, k4});
      if (i == 2) i_mode = 2'd2;
    end
    wait_out(12);
    for (int i = 0; i < 12; i++) begin
      e = 8'((i + 1) * 17);
      if (i >= 8) e = ~e;
      check_out("latch", i, e, (i == 0 || i == 8), (i % 4 == 3), 1);
    end

    // Backpressure fill, stall cycles, in-order drain, then complete three frames
    apply_reset();
    i_mode = 2'd0;
    i_data_ready = 1'b0;
    for (int k = 0; k < 15; k++) begin
      k4 = 4'(k);
      push({k4, k4, k4});
    end
    i_data_valid = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(posedge i_clk); #1;
    end
    i_data_valid = 1'b0;
    check("full_fill", o_fill, 15);
    check("full_ready", o_data_ready, 0);
    check("full_head", o_data, 0);
    i_data_ready = 1'b1;
    wait_out(15);
    for (int k = 0; k < 15; k++) check_out("drain", k, 8'(k * 17), 1'b0, 1'b0, 0);
    @(posedge i_clk); #1;
    check("drained_fill", o_fill, 0);
    for (int k = 0; k < 9; k++) push(12'h123);
    repeat (4) @(posedge i_clk);
    #1;
`ifdef VP_PIXEL_PIPE_STATS_EN
    exp_fc = 3;
    exp_st = 10;
`else
    exp_fc = 0;
    exp_st = 0;
`endif
    check("frame_count", o_frame_count, exp_fc);
    check("stall_cycles", o_stall_cycles, exp_st);

    // Mid-operation reset flushes the FIFO; next pixel starts a new frame
    apply_reset();
    i_mode = 2'd0;
    i_data_ready = 1'b0;
    for (int k = 0; k < 5; k++) push(12'hF00);
    repeat (3) @(posedge i_clk);
    #1;
    check("pre_rst_fill", o_fill, 5);
    i_rstn = 1'b0;
    @(negedge i_clk);
    check("in_rst_ready", o_data_ready, 0);
    @(posedge i_clk); #1;
    i_rstn = 1'b1;
    check("post_rst_fill", o_fill, 0);
    check("post_rst_valid", o_data_valid, 0);
    check("post_rst_data", o_data, 0);
    i_data_ready = 1'b1;
    outq.delete();
    push(12'h0F0);
    wait_out(1);
    check_out("post_rst_px", 0, 8'd149, 1'b1, 1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vp_pixel_pipe.md
# vp_pixel_pipe

Full-throughput successor to the single-pixel-per-two-cycle camera-side video processor. It accepts RGB pixels from the camera path over a ready/valid handshake at up to one pixel per clock, with parametrised channel and output widths. Each pixel is converted to grayscale and passed through a run-time selectable point operation (gray, binary threshold, invert, threshold-to-zero). Results are tagged with start-of-frame and end-of-line markers from internal raster counters and buffered in a first-word-fall-through output FIFO toward the memory path.

## Interface
Parameters:
- CW, 4: bits per input colour channel; input pixel is {R,G,B}, 3*CW bits; CW <= DW.
- DW, 8: output pixel width.
- RL, 640: pixels per line.
- FL, 480: lines per frame.
- AW, 10: FIFO address width; depth 2^AW; AW >= 3.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  reset, synchronous, active-low.
- i_mode  in  2  operation: 0 gray, 1 binary threshold, 2 invert, 3 threshold-to-zero.
- i_threshold  in  DW  threshold value.
- i_data_valid  in  1  upstream pixel valid.
- o_data_ready  out  1  upstream ready.
- i_data  in  3*CW  RGB pixel.
- i_data_ready  in  1  downstream ready.
- o_data_valid  out  1  FIFO head valid.
- o_data  out  DW  FIFO head pixel.
- o_sof  out  1  head pixel is frame pixel (0,0).
- o_eol  out  1  head pixel is last of its line.
- o_fill  out  AW+1  FIFO occupancy.
- o_frame_count  out  16  see Configuration.
- o_stall_cycles  out  32  see Configuration.

## Operation
- Accept: a pixel transfers on an edge where i_data_valid && o_data_ready.
- o_data_ready = i_rstn && (o_fill <= 2^AW - 4). This guarantees the FIFO never overflows with two pixels in flight.
- Raster counters col (0..RL-1) and row (0..FL-1) advance on each accept.
  - col wraps at RL-1 and row increments.
  - row wraps at FL-1.
  - Tags: sof = (col==0 && row==0); eol = (col==RL-1).
- Mode latch: i_mode and i_threshold are captured only on accept of an sof pixel. Mid-frame changes take effect at the next frame.
- Stage 1 (accept edge): register the pixel, tags, and latched mode.
  - Each channel is widened to DW bits by MSB bit-replication; e.g. 4'hF becomes 8'hFF.
- Stage 2: gray = (77*R + 150*G + 29*B) >> 8.
  - Unsigned, truncating; computed at DW+8 bits; result is DW bits.
- Stage 3 (FIFO write), by mode:
  - 0: gray.
  - 1: gray >= thr ? all-ones : 0.
  - 2: ~gray.
  - 3: gray >= thr ? gray : 0.
- FIFO: width DW+2 ({sof, eol, pixel}), first-word-fall-through.
  - o_data_valid = !empty; head is on o_data / o_sof / o_eol.
  - Pop on o_data_valid && i_data_ready. i_data_ready while empty is ignored.
  - Simultaneous push and pop leaves o_fill unchanged.
  - Push while full cannot occur; the bench asserts this.

## Timing
- Reset values: o_data_ready 0, o_data_valid 0, o_data 0, o_sof 0, o_eol 0, o_fill 0, counters 0, latched mode 0, threshold 0, pipeline valids 0.
- Reset mid-operation flushes the FIFO and pipeline. The first pixel accepted after reset carries sof.
- Latency: pixel accepted at edge N is written at edge N+2. o_data_valid is high in the cycle after edge N+2 if the FIFO was empty.
- Throughput: one pixel per clock while o_fill <= 2^AW - 4 and downstream drains.
- o_fill updates on the write/read edge. o_data_ready follows combinationally from o_fill.

## Configuration
- VP_PIXEL_PIPE_STATS_EN defined:
  - o_frame_count increments on accept of each pixel with row==FL-1 && col==RL-1, wrapping at 16 bits.
  - o_stall_cycles increments each cycle with i_data_valid && !o_data_ready, saturating at 32'hFFFFFFFF.
  - Both counters clear on reset.
- Not defined: both ports tie to 0 and no counter logic is built.

## Test plan
- CW=4, DW=8, mode 0, i_data_ready=1. Stream F00, 0F0, 00F, FFF, 000 back-to-back -> o_data 76, 149, 28, 255, 0. First o_data_valid 3 cycles after the first accept; one output per cycle.
- Same stream:
  - mode 1, thr 100 -> 0, 255, 0, 255, 0.
  - mode 2 -> 179, 106, 227, 0, 255.
  - mode 3, thr 100 -> 0, 149, 0, 255, 0.
- AW=4, i_data_ready=0, continuous valid -> exactly 15 pixels accepted. o_fill settles at 15, o_data_ready stays 0, no overflow. Releasing i_data_ready drains 15 values in order.
- RL=4, FL=2, mode 0 at frame start; set i_mode=2 after the 3rd pixel -> pixels 0-7 stay gray. o_sof on pixel 0 and 8. o_eol on pixels 3, 7, 11. Inversion starts at pixel 8.
- With o_fill=5, pull i_rstn low for 1 cycle -> next cycle o_fill 0, o_data_valid 0. The next accepted pixel emerges with o_sof=1.
- STATS_EN, RL=4, FL=2: 3 frames plus 10 forced stall cycles -> o_frame_count 3, o_stall_cycles 10. Without the macro, both read 0.
